// File: rtl/count_event_capture.sv
// count_event_capture: detects match/wrap/restart events on a sampled counter value and queues them in a FIFO
// Ports: clk, reset (async, active-high); value/cmp sampled every edge; arm enables detection;
//        out_valid/out_ready/out_data drain the queue ({match_also, type[1:0], value[7:0]});
//        dropped is a sticky overflow flag cleared by clr_drop.
module count_event_capture #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic [7:0]  cmp,
    input  logic        arm,
    input  logic        out_ready,
    input  logic        clr_drop,
    output logic        out_valid,
    output logic [10:0] out_data,
    output logic        dropped
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    logic [7:0]    prev_q;
    logic          prev_valid_q;
    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dropped_q, dropped_d;
    logic          det, wrap, restart, match, push, pop, full, wr_en;
    logic [10:0]   entry;
    always_comb begin
        det       = arm && prev_valid_q;
        wrap      = det && prev_q == 8'hFF && value == 8'h00;
        restart   = det && value < prev_q && !wrap;
        match     = det && value == cmp && value != prev_q;
        push      = wrap || restart || match;
        entry     = {match && (wrap || restart), wrap ? 2'b10 : restart ? 2'b11 : 2'b01, value};
        out_valid = |cnt_q;
        pop       = out_valid && out_ready;
        full      = cnt_q == CW'(DEPTH);
        // a pop frees the head slot at this same edge, so a full FIFO still accepts the push
        wr_en     = push && (!full || pop);
        wr_d      = wr_q + AW'(wr_en);
        rd_d      = rd_q + AW'(pop);
        cnt_d     = cnt_q + CW'(wr_en) - CW'(pop);
        // a fresh drop outranks a simultaneous clear
        dropped_d = (push && full && !pop) ? 1'b1 : clr_drop ? 1'b0 : dropped_q;
        out_data  = mem_q[rd_q];
        dropped   = dropped_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            dropped_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            prev_q       <= arm ? value : prev_q;
            prev_valid_q <= arm;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            dropped_q    <= dropped_d;
            if (wr_en) mem_q[wr_q] <= entry;
        end
    end
endmodule

// File: tb/tb_count_event_capture.sv
// tb_count_event_capture: directed vector bench for count_event_capture
module tb_count_event_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  value = '0;
    logic [7:0]  cmp = '0;
    logic        arm = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_drop = 1'b0;
    logic        out_valid;
    logic [10:0] out_data;
    logic        dropped;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0]  v;
        logic [7:0]  c;
        logic        a;
        logic        r;
        logic        ev;
        logic [10:0] ed;
    } vec_t;
    vec_t tbl[$];

    count_event_capture #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .value(value), .cmp(cmp), .arm(arm),
        .out_ready(out_ready), .clr_drop(clr_drop),
        .out_valid(out_valid), .out_data(out_data), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask

    task automatic expect_out(input string n, input logic ev, input logic [10:0] ed, input logic edrop);
        chk({n, "_valid"}, 32'(out_valid), 32'(ev));
        if (ev) chk({n, "_data"}, 32'(out_data), 32'(ed));
        chk({n, "_dropped"}, 32'(dropped), 32'(edrop));
    endtask

    task automatic step(input logic [7:0] v, input logic [7:0] c, input logic a, input logic r, input logic cl);
        value = v;
        cmp = c;
        arm = a;
        out_ready = r;
        clr_drop = cl;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t row(input logic [7:0] v, input logic [7:0] c, input logic a,
                                 input logic ev, input logic [10:0] ed);
        vec_t t;
        t.v = v; t.c = c; t.a = a; t.r = 1'b1; t.ev = ev; t.ed = ed;
        return t;
    endfunction

    initial begin
        // counter run: match at 0x05, wraps with and without match, restart, restart+match
        tbl.push_back(row(8'h00, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'h01, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'h02, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'h03, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'h04, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'h05, 8'h05, 1, 1, 11'h105));
        tbl.push_back(row(8'h06, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'h07, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'hFE, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'hFF, 8'h00, 1, 0, 11'h000));
        tbl.push_back(row(8'h00, 8'h00, 1, 1, 11'h600));
        tbl.push_back(row(8'h01, 8'h80, 1, 0, 11'h000));
        tbl.push_back(row(8'hFE, 8'h80, 1, 0, 11'h000));
        tbl.push_back(row(8'hFF, 8'h80, 1, 0, 11'h000));
        tbl.push_back(row(8'h00, 8'h80, 1, 1, 11'h200));
        tbl.push_back(row(8'h01, 8'h80, 1, 0, 11'h000));
        tbl.push_back(row(8'h0A, 8'h77, 1, 0, 11'h000));
        tbl.push_back(row(8'h0B, 8'h77, 1, 0, 11'h000));
        tbl.push_back(row(8'h00, 8'h77, 1, 1, 11'h300));
        tbl.push_back(row(8'h01, 8'h77, 1, 0, 11'h000));
        tbl.push_back(row(8'h05, 8'h02, 1, 0, 11'h000));
        tbl.push_back(row(8'h02, 8'h02, 1, 1, 11'h702));
        tbl.push_back(row(8'h03, 8'h02, 1, 0, 11'h000));
        // value held at cmp: one match only
        tbl.push_back(row(8'h04, 8'h05, 1, 0, 11'h000));
        tbl.push_back(row(8'h05, 8'h05, 1, 1, 11'h105));
        for (int i = 0; i < 9; i++) tbl.push_back(row(8'h05, 8'h05, 1, 0, 11'h000));
        // wrap while disarmed, then re-arm: first sample only rebuilds history
        tbl.push_back(row(8'hFE, 8'h80, 1, 0, 11'h000));
        tbl.push_back(row(8'hFF, 8'h80, 0, 0, 11'h000));
        tbl.push_back(row(8'h00, 8'h00, 0, 0, 11'h000));
        tbl.push_back(row(8'h01, 8'h01, 1, 0, 11'h000));
        tbl.push_back(row(8'h02, 8'h01, 1, 0, 11'h000));
        tbl.push_back(row(8'h03, 8'h03, 1, 1, 11'h103));
        tbl.push_back(row(8'h04, 8'h03, 1, 0, 11'h000));

        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_dropped", 32'(dropped), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].r, 1'b0);
            expect_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, 1'b0);
        end

        // counter restarted mid-count coincides with this block's own reset: no event afterwards
        step(8'h0A, 8'h77, 1, 1, 0);
        step(8'h0B, 8'h77, 1, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        expect_out("midrst", 1'b0, 11'h000, 1'b0);
        chk("midrst_data", 32'(out_data), 0);
        value = 8'h00;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_rst0", 1'b0, 11'h000, 1'b0);
        step(8'h01, 8'h77, 1, 1, 0);
        expect_out("post_rst1", 1'b0, 11'h000, 1'b0);

        // overflow: five matches with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            step(8'h10 + 8'(i), 8'h10 + 8'(i), 1, 0, 0);
            expect_out($sformatf("fill%0d", i), 1'b1, 11'h110, i == 4);
        end
        for (int i = 1; i < 4; i++) begin
            step(8'h14, 8'h14, 1, 1, 0);
            expect_out($sformatf("drain%0d", i), 1'b1, 11'h110 + 11'(i), 1'b1);
        end
        step(8'h14, 8'h14, 1, 1, 0);
        expect_out("drain_empty", 1'b0, 11'h000, 1'b1);
        step(8'h14, 8'h14, 1, 1, 1);
        expect_out("clr_drop", 1'b0, 11'h000, 1'b0);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            step(8'h20 + 8'(i), 8'h20 + 8'(i), 1, 0, 0);
            expect_out($sformatf("full%0d", i), 1'b1, 11'h120, 1'b0);
        end
        step(8'h24, 8'h24, 1, 1, 0);
        expect_out("pushpop", 1'b1, 11'h121, 1'b0);
        for (int i = 2; i < 5; i++) begin
            step(8'h24, 8'h24, 1, 1, 0);
            expect_out($sformatf("pp_drain%0d", i), 1'b1, 11'h120 + 11'(i), 1'b0);
        end
        step(8'h24, 8'h24, 1, 1, 0);
        expect_out("pp_empty", 1'b0, 11'h000, 1'b0);

        // drop and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) step(8'h30 + 8'(i), 8'h30 + 8'(i), 1, 0, 0);
        step(8'h34, 8'h34, 1, 0, 1);
        expect_out("setwins", 1'b1, 11'h130, 1'b1);
        step(8'h34, 8'h34, 1, 0, 1);
        expect_out("clr_after", 1'b1, 11'h130, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
